// File: rtl/parity_frame_tx_pkg.sv
// Shared types and defaults for the parity frame transmitter.
// Used by parity_frame_tx and baud_tick_gen.
package parity_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DEFAULT_DATA_W       = 32;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_STOP_BITS    = 1;

endpackage

// File: rtl/parity_frame_tx_baud_tick_gen.sv
// Per-state cycle counter: raises bit_tick on the cycle the count hits term_cnt,
// and restarts from zero on a tick, on a state change, or while disabled.
module baud_tick_gen
  import parity_frame_tx_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] term_cnt,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_tick
);

  logic [CNT_W-1:0] cnt_r;

  assign cnt      = cnt_r;
  assign bit_tick = en && (cnt_r == term_cnt);

  // Cycle counter within the current serial bit (or the whole stop period).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!en || clear || bit_tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

endmodule

// File: rtl/parity_frame_tx.sv
// UART-style frame transmitter: start, DATA_W bits LSB-first, parity, stop bit(s).
// Optional macro PARITY_CHECK_EN adds the parity_err input-consistency checker.
module parity_frame_tx
  import parity_frame_tx_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_serial,
  output logic              busy,
  output logic              frame_done
`ifdef PARITY_CHECK_EN
  ,output logic             parity_err
`endif
);

  localparam int CNT_W = (STOP_BITS * CLKS_PER_BIT > 1) ? $clog2(STOP_BITS * CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_TERM  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_TERM = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  // frame_done is registered, so it is armed one cycle before the final stop cycle.
  localparam logic [CNT_W-1:0] DONE_ARM  = CNT_W'(STOP_BITS * CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  tx_state_e         state_r, next_state_s;
  logic [DATA_W-1:0] shift_r, shift_next_s;
  logic              parity_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic              tx_r, tx_next_s;
  logic              in_ready_r, busy_r, frame_done_r, frame_done_next_s;
  logic              xfer_s, state_chg_s, cnt_en_s, bit_tick_s;
  logic [CNT_W-1:0]  term_s, cycle_cnt_s;

  assign state_chg_s = (next_state_s != state_r);
  assign cnt_en_s    = (state_r != IDLE);
  assign term_s      = (state_r == STOP) ? STOP_TERM : BIT_TERM;

  baud_tick_gen #(.CNT_W(CNT_W)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en_s),
    .clear    (state_chg_s),
    .term_cnt (term_s),
    .cnt      (cycle_cnt_s),
    .bit_tick (bit_tick_s)
  );

  // Next-state, transfer capture and shift-register update.
  always_comb begin
    next_state_s = state_r;
    shift_next_s = shift_r;
    xfer_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = START;
          shift_next_s = data_in;
          xfer_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (bit_tick_s) next_state_s = DATA;
        else            next_state_s = START;
      end
      DATA: begin
        if (bit_tick_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            next_state_s = PARITY;
          end else begin
            shift_next_s = shift_r >> 1;
          end
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_tick_s) next_state_s = STOP;
        else            next_state_s = PARITY;
      end
      STOP: begin
        if (bit_tick_s) next_state_s = IDLE;
        else            next_state_s = STOP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Line level for the coming cycle, so tx_serial can be a plain flop.
  always_comb begin
    tx_next_s = 1'b1;
    case (next_state_s)
      IDLE:    tx_next_s = 1'b1;
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      PARITY:  tx_next_s = parity_r;
      STOP:    tx_next_s = 1'b1;
      default: tx_next_s = 1'b1;
    endcase
  end

  // Arm frame_done so it lands on the last stop cycle.
  always_comb begin
    if ((state_r == STOP) && (cycle_cnt_s == DONE_ARM)) begin
      frame_done_next_s = 1'b1;
    end else begin
      frame_done_next_s = 1'b0;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_r      <= '0;
      parity_r     <= 1'b0;
      bit_cnt_r    <= '0;
      tx_r         <= 1'b1;
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      shift_r      <= shift_next_s;
      parity_r     <= xfer_s ? parity_in : parity_r;
      if (state_chg_s) begin
        bit_cnt_r <= '0;
      end else if ((state_r == DATA) && bit_tick_s) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      tx_r         <= tx_next_s;
      in_ready_r   <= (next_state_s == IDLE);
      busy_r       <= (next_state_s != IDLE);
      frame_done_r <= frame_done_next_s;
    end
  end

  assign tx_serial  = tx_r;
  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

`ifdef PARITY_CHECK_EN
  logic parity_err_r;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Flag a source whose parity bit disagrees with its data; the frame still uses parity_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= xfer_s && (even_parity(data_in) != parity_in);
    end
  end

  assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx (CLKS_PER_BIT=4, STOP_BITS=1).
// Optional macro PARITY_CHECK_EN enables the parity_err checks.
module tb_parity_frame_tx;

  localparam int DW        = 32;
  localparam int CPB       = 4;
  localparam int SB        = 1;
  localparam int FRAME_CYC = (DW + 2 + SB) * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        parity_in;
  logic        in_valid;
  logic        in_ready, tx_serial, busy, frame_done;
`ifdef PARITY_CHECK_EN
  logic        parity_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .parity_in  (parity_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_serial  (tx_serial),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef PARITY_CHECK_EN
    ,.parity_err (parity_err)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        par;
    logic        exp_err;
    logic        scramble;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line level k cycles after the transfer cycle: start, data LSB-first, parity, stop.
  function automatic logic exp_tx(input logic [31:0] d, input logic p, input int k);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (b == DW + 1) return p;
    return 1'b1;
  endfunction

  // Watch one frame whose transfer edge just occurred; optionally queue the next word.
  task automatic run_frame(input logic [31:0] d, input logic p, input logic ee, input logic scr,
                           input logic nv, input logic [31:0] nd, input logic np);
    int tx_bad, st_bad, done_cnt, done_at, perr_cnt, perr_at, b;
    logic [31:0] dec;
    logic        dec_p;
    tx_bad = 0; st_bad = 0; done_cnt = 0; done_at = 0; perr_cnt = 0; perr_at = 0;
    dec = 32'h0; dec_p = 1'b0;
    for (int k = 1; k <= FRAME_CYC; k++) begin
      @(negedge clk);
      if (tx_serial !== exp_tx(d, p, k)) tx_bad++;
      if (busy !== 1'b1 || in_ready !== 1'b0) st_bad++;
      if (frame_done === 1'b1) begin done_cnt++; done_at = k; end
`ifdef PARITY_CHECK_EN
      if (parity_err === 1'b1) begin perr_cnt++; perr_at = k; end
`endif
      if (((k - 1) % CPB) == CPB / 2) begin
        b = (k - 1) / CPB;
        if (b >= 1 && b <= DW) dec[b-1] = tx_serial;
        else if (b == DW + 1) dec_p = tx_serial;
      end
      if (k == 1) begin
        in_valid = nv; data_in = nd; parity_in = np;
      end else if (scr) begin
        data_in = $urandom;
      end
    end
    check("tx_bits", tx_bad, 0);
    check("busy_ready", st_bad, 0);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, FRAME_CYC);
    check("decoded_word", dec, d);
    check("decoded_parity", {31'h0, dec_p}, {31'h0, p});
`ifdef PARITY_CHECK_EN
    check("perr_count", perr_cnt, {31'h0, ee});
    if (ee) check("perr_cycle", perr_at, 1);
`else
    if (ee && (perr_cnt != 0 || perr_at != 0)) check("perr_absent", perr_cnt, 0);
`endif
    @(negedge clk);
    check("after_frame", {in_ready, busy, tx_serial, frame_done}, 4'b1010);
  endtask

  task automatic send(input logic [31:0] d, input logic p, input logic ee, input logic scr);
    @(negedge clk);
    data_in = d; parity_in = p; in_valid = 1'b1;
    check("ready_before_send", in_ready, 1);
    @(posedge clk);
    run_frame(d, p, ee, scr, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    vec_t        vecs[5];
    int          bad, dn;
    logic [31:0] rd;
    logic        rp;

    vecs[0] = '{32'h0000_0003, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0003, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; data_in = 32'h0; parity_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, busy, tx_serial, frame_done}, 4'b1010);
`ifdef PARITY_CHECK_EN
    check("reset_perr", parity_err, 0);
`endif
    rst = 1'b0;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({in_ready, busy, tx_serial, frame_done} !== 4'b1010) bad++;
    end
    check("idle_100", bad, 0);

    send(32'h0000_0001, 1'b1, 1'b0, 1'b0);

    // Back-to-back: the second word is held valid during the first frame.
    @(negedge clk);
    data_in = 32'hA5A5_A5A5; parity_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    run_frame(32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    run_frame(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data, vecs[i].par, vecs[i].exp_err, vecs[i].scramble);
    end

    for (int i = 0; i < 6; i++) begin
      rd = $urandom;
      rp = ^rd;
`ifdef PARITY_CHECK_EN
      if (i % 3 == 2) rp = ~rp;
`endif
      send(rd, rp, (rp != ^rd), i[0]);
    end

    // Reset 60 cycles into a frame of zeros: line must jump high and no frame_done.
    @(negedge clk);
    data_in = 32'h0; parity_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    dn = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (frame_done === 1'b1) dn++;
    end
    check("pre_reset_tx", tx_serial, 0);
    rst = 1'b1;
    #1;
    check("reset_abort", {in_ready, busy, tx_serial, frame_done}, 4'b1010);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) dn++;
      if (tx_serial !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("no_done_after_abort", dn, 0);
    check("idle_after_abort", bad, 0);
    send(32'h1234_5678, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Serial framing transmitter placed directly downstream of the 32-bit even-parity generator. It accepts one data word and its generated parity bit over a valid/ready handshake. It then shifts out one UART-style frame on a single line, in this order: start bit, data LSB-first, parity bit, stop bit(s). It is the bridge between the parity datapath and the board-level serial pin.

Parameters:
DATA_W, 32, width of the data word; must match the parity generator input width.
CLKS_PER_BIT, 16, clock cycles per serial bit; legal values are ≥2.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  asynchronous, active-high reset.
data_in  input  DATA_W  word to transmit.
parity_in  input  1  parity bit from the parity generator for data_in.
in_valid  input  1  data_in/parity_in are valid.
in_ready  output  1  block can accept a word this cycle.
tx_serial  output  1  serial line; idles high.
busy  output  1  a frame is in progress.
frame_done  output  1  one-cycle pulse on the final cycle of the last stop bit.
parity_err  output  1  present only when PARITY_CHECK_EN is defined (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; tx_serial=1, in_ready=1, busy=0, frame_done=0, parity_err=0.
  - bit/cycle counters and shift register cleared.
  - Reset mid-frame aborts the frame at once; tx_serial goes high asynchronously and no frame_done is produced.
- Handshake:
  - in_ready = (state==IDLE).
  - Transfer occurs when in_valid && in_ready on a rising edge.
  - On transfer, data_in and parity_in are captured into registers. Later input changes are ignored until the next transfer.
  - in_valid while busy is held off and not dropped; the source keeps it asserted.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: tx_serial=1. Transfer moves to START on the next edge.
  - START: tx_serial=0 for CLKS_PER_BIT cycles.
  - DATA: tx_serial=shift_reg[0]. Shift right every CLKS_PER_BIT cycles. Bit counter runs 0..DATA_W-1, then moves to PARITY.
  - PARITY: tx_serial=captured parity for CLKS_PER_BIT cycles.
  - STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 on the last of those cycles, then return to IDLE.
- Latency:
  - tx_serial falls on the first cycle after the transfer edge.
  - Frame length is (DATA_W+2+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back: in_ready returns high the cycle after frame_done. The earliest next transfer is that cycle, so there is no gap beyond one idle cycle.
- busy = (state!=IDLE). frame_done is registered and high for exactly one cycle per completed frame.
- Counter widths: cycle counter is $clog2(STOP_BITS*CLKS_PER_BIT) bits; bit counter is $clog2(DATA_W) bits. Neither wraps within a state; both clear on every state change.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - On transfer, the block computes the XOR-reduction of data_in internally and compares it with parity_in.
  - On mismatch, parity_err is registered and pulses high for one cycle, coincident with the START state's first cycle.
  - The frame is still sent using parity_in unchanged.
- Undefined: the parity_err port and checker logic are absent, and the block trusts parity_in.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP (3-bit).
  - Default constants: DATA_W=32, CLKS_PER_BIT=16.
- One natural sub-module: baud_tick_gen. It is a cycle counter producing a bit_tick every CLKS_PER_BIT cycles, cleared on state change. The FSM, shift register and bit counter stay in parity_frame_tx.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1):
- Reset then idle → tx_serial=1, in_ready=1, busy=0. No activity for 100 cycles with in_valid=0.
- data_in=0x0000_0001, parity_in=1, single pulse →
  - tx_serial sampled mid-bit reads 0, 1, 0×31, 1, 1.
  - frame_done pulses exactly 140 cycles after transfer.
  - in_ready is high 1 cycle later.
- Two words held valid, 0xA5A5_A5A5 (parity 0) then 0xFFFF_FFFF (parity 0) → two contiguous frames.
  - Second START begins 1 cycle after the first frame_done.
  - Decoded words match the inputs.
- data_in changed every cycle during a frame → transmitted bits equal the value captured at transfer.
- rst asserted 60 cycles into a frame → tx_serial=1 immediately, no frame_done. After release, a new word 0x1234_5678 (parity 1) transmits correctly.
- With PARITY_CHECK_EN: data_in=0x0000_0003, parity_in=1 → parity_err pulses once and the frame parity bit is 1. With parity_in=0 → no parity_err.
